// File: rtl/multicycle_control.sv
// Moore-style sequencer for a shared-memory multi-cycle MIPS-subset datapath.
// Control outputs are decoded from the current state. Some are qualified by
// mem_ready, Zero or Overflow in the same cycle. The memory timeout pulse
// (mem_err) is the only registered output.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       Overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWr,
  output logic       IorD,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] PC_Sel,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       Extop,
  output logic [2:0] ALUctr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal,
  output logic       mem_err,
  output logic       ovf_trap,
  output logic [3:0] state_o
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nx;
  logic             mem_err_nx;
  logic             mem_wait;

  logic [ALU_W-1:0] r_aluctr;
  logic             r_legal;
  logic             r_arith;

  // State, wait counter and registered timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      mem_err  <= mem_err_nx;
    end
  end

  // R-type function decode; add/sub are the only overflow-trapping ops.
  always_comb begin
    r_aluctr = ALU_ADD;
    r_legal  = 1'b1;
    r_arith  = 1'b0;
    unique case (func)
      FN_ADD:  begin r_aluctr = ALU_ADD; r_arith = 1'b1; end
      FN_SUB:  begin r_aluctr = ALU_SUB; r_arith = 1'b1; end
      FN_AND:  r_aluctr = ALU_AND;
      FN_OR:   r_aluctr = ALU_OR;
      FN_SLT:  r_aluctr = ALU_SLT;
      default: r_legal  = 1'b0;
    endcase
  end

  // Next-state, per-state outputs and memory wait/timeout handling.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    mem_err_nx  = 1'b0;
    mem_wait    = 1'b0;
    mem_req     = 1'b0;
    MemWr       = 1'b0;
    IorD        = 1'b0;
    IRWr        = 1'b0;
    PCWr        = 1'b0;
    PC_Sel      = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    Extop       = 1'b0;
    ALUctr      = ALU_ADD;
    RegWr       = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    illegal     = 1'b0;
    ovf_trap    = 1'b0;

    unique case (state)
      S_INIT: state_nx = S_FETCH;

      S_FETCH: begin
        mem_wait = 1'b1;
        mem_req  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWr     = mem_ready;
        PCWr     = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        Extop   = 1'b1;
        unique case (op)
          OP_RTYPE:       state_nx = S_EXEC;
          OP_LW, OP_SW:   state_nx = S_MEMADR;
          OP_BEQ:         state_nx = S_BRANCH;
          OP_J:           state_nx = S_JUMP;
          OP_ADDI, OP_ORI: state_nx = S_IMMEX;
          default: begin
            illegal  = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        Extop    = 1'b1;
        state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_wait = 1'b1;
        mem_req  = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end

      S_MEMWB: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
        state_nx = S_FETCH;
      end

      S_MEMWR: begin
        mem_wait = 1'b1;
        mem_req  = 1'b1;
        MemWr    = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUctr  = r_aluctr;
        if (r_legal) begin
          state_nx = S_ALUWB;
        end else begin
          illegal  = 1'b1;
          state_nx = S_FETCH;
        end
      end

      S_ALUWB: begin
        RegDst   = 1'b1;
        ALUctr   = r_aluctr;
        ovf_trap = Overflow & r_arith;
        RegWr    = ~(Overflow & r_arith);
        state_nx = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUctr   = ALU_SUB;
        PC_Sel   = 2'b01;
        PCWr     = Zero;
        state_nx = S_FETCH;
      end

      S_JUMP: begin
        PCWr     = 1'b1;
        PC_Sel   = 2'b10;
        state_nx = S_FETCH;
      end

      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op == OP_ADDI) begin
          Extop  = 1'b1;
          ALUctr = ALU_ADD;
        end else if (op == OP_ORI) begin
          ALUctr = ALU_OR;
        end
        state_nx = S_IMMWB;
      end

      S_IMMWB: begin
        ALUctr   = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        ovf_trap = Overflow & (op == OP_ADDI);
        RegWr    = ~(Overflow & (op == OP_ADDI));
        state_nx = S_FETCH;
      end

      default: state_nx = S_INIT;
    endcase

    // Count stalled memory cycles; the last tolerated stall aborts to FETCH.
    // A ready on the final cycle completes normally.
    if (mem_wait && !mem_ready) begin
      if (wait_cnt == CNT_LAST) begin
        state_nx    = S_FETCH;
        wait_cnt_nx = '0;
        mem_err_nx  = 1'b1;
      end else begin
        wait_cnt_nx = wait_cnt + CNT_W'(1);
      end
    end else if (state_nx != state) begin
      wait_cnt_nx = '0;
    end
  end

  assign state_o = 4'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a scoreboard: stimulus pushes the
// expected per-cycle output vector, a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_IMMEX  = 4'd11;
  localparam logic [3:0] S_IMMWB  = 4'd12;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       memwr;
    logic       iord;
    logic       irwr;
    logic       pcwr;
    logic [1:0] pc_sel;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] aluctr;
    logic       regwr;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
    logic       mem_err;
    logic       ovf_trap;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] func;
  logic       Zero;
  logic       Overflow;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWr;
  logic       IorD;
  logic       IRWr;
  logic       PCWr;
  logic [1:0] PC_Sel;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       Extop;
  logic [2:0] ALUctr;
  logic       RegWr;
  logic       RegDst;
  logic       MemtoReg;
  logic       illegal;
  logic       mem_err;
  logic       ovf_trap;
  logic [3:0] state_o;

  out_t  exp_q[$];
  string nm_q[$];
  out_t  act;
  out_t  mon_e;
  string mon_nm;
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .Zero(Zero),
    .Overflow(Overflow), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWr(MemWr), .IorD(IorD), .IRWr(IRWr), .PCWr(PCWr), .PC_Sel(PC_Sel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Extop(Extop), .ALUctr(ALUctr),
    .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal(illegal),
    .mem_err(mem_err), .ovf_trap(ovf_trap), .state_o(state_o)
  );

  always_comb begin
    act.st       = state_o;
    act.mem_req  = mem_req;
    act.memwr    = MemWr;
    act.iord     = IorD;
    act.irwr     = IRWr;
    act.pcwr     = PCWr;
    act.pc_sel   = PC_Sel;
    act.alusrca  = ALUSrcA;
    act.alusrcb  = ALUSrcB;
    act.extop    = Extop;
    act.aluctr   = ALUctr;
    act.regwr    = RegWr;
    act.regdst   = RegDst;
    act.memtoreg = MemtoReg;
    act.illegal  = illegal;
    act.mem_err  = mem_err;
    act.ovf_trap = ovf_trap;
  end

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      n_checks++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got state %0d vec %h, required state %0d vec %h",
                 mon_nm, act.st, act, mon_e.st, mon_e);
      end
    end
  end

  // State-fixed outputs, written from the state table; qualified bits added by callers.
  function automatic out_t base(input logic [3:0] s);
    out_t e;
    e = '0;
    e.st = s;
    case (s)
      S_FETCH:  begin e.mem_req = 1'b1; e.alusrcb = 2'b01; end
      S_DECODE: begin e.alusrcb = 2'b11; e.extop = 1'b1; end
      S_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.extop = 1'b1; end
      S_MEMRD:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
      S_MEMWB:  begin e.regwr = 1'b1; e.memtoreg = 1'b1; end
      S_MEMWR:  begin e.mem_req = 1'b1; e.memwr = 1'b1; e.iord = 1'b1; end
      S_EXEC:   e.alusrca = 1'b1;
      S_ALUWB:  e.regdst = 1'b1;
      S_BRANCH: begin e.alusrca = 1'b1; e.aluctr = 3'b001; e.pc_sel = 2'b01; end
      S_JUMP:   begin e.pcwr = 1'b1; e.pc_sel = 2'b10; end
      S_IMMEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      default:  ;
    endcase
    return e;
  endfunction

  task automatic step(input string nm, input out_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic plain(input string nm, input logic [3:0] s);
    step(nm, base(s));
  endtask

  task automatic fetch_ok(input string nm);
    out_t e;
    mem_ready = 1'b1;
    e = base(S_FETCH);
    e.irwr = 1'b1;
    e.pcwr = 1'b1;
    step(nm, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e;
    rst_n = 1'b0; op = '0; func = '0; Zero = 1'b0; Overflow = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    plain("init_after_reset", S_INIT);

    // lw with three stalled MEMRD cycles; ready arrives on the last tolerated one
    op = 6'b100011;
    fetch_ok("lw_fetch");
    mem_ready = 1'b0;
    plain("lw_decode", S_DECODE);
    plain("lw_memadr", S_MEMADR);
    repeat (3) plain("lw_memrd_wait", S_MEMRD);
    mem_ready = 1'b1;
    plain("lw_memrd_done", S_MEMRD);
    mem_ready = 1'b0;
    plain("lw_memwb", S_MEMWB);

    // R-type add
    op = 6'b000000; func = 6'b100000;
    fetch_ok("add_fetch");
    plain("add_decode", S_DECODE);
    plain("add_exec", S_EXEC);
    e = base(S_ALUWB); e.regwr = 1'b1;
    step("add_aluwb", e);

    // R-type sub with overflow: writeback suppressed
    func = 6'b100010;
    fetch_ok("sub_fetch");
    plain("sub_decode", S_DECODE);
    e = base(S_EXEC); e.aluctr = 3'b001;
    step("sub_exec", e);
    Overflow = 1'b1;
    e = base(S_ALUWB); e.aluctr = 3'b001; e.ovf_trap = 1'b1;
    step("sub_aluwb_ovf", e);

    // slt ignores overflow; trap must not linger into next fetch
    func = 6'b101010;
    fetch_ok("slt_fetch_trap_gone");
    plain("slt_decode", S_DECODE);
    e = base(S_EXEC); e.aluctr = 3'b100;
    step("slt_exec", e);
    e = base(S_ALUWB); e.aluctr = 3'b100; e.regwr = 1'b1;
    step("slt_aluwb_no_trap", e);
    Overflow = 1'b0;

    // unsupported func
    func = 6'b001000;
    fetch_ok("badfunc_fetch");
    plain("badfunc_decode", S_DECODE);
    e = base(S_EXEC); e.illegal = 1'b1;
    step("badfunc_exec_illegal", e);

    // beq taken / not taken
    op = 6'b000100;
    fetch_ok("beq_t_fetch");
    plain("beq_t_decode", S_DECODE);
    Zero = 1'b1;
    e = base(S_BRANCH); e.pcwr = 1'b1;
    step("beq_taken", e);
    Zero = 1'b0;
    fetch_ok("beq_n_fetch");
    plain("beq_n_decode", S_DECODE);
    plain("beq_not_taken", S_BRANCH);

    // jump
    op = 6'b000010;
    fetch_ok("j_fetch");
    plain("j_decode", S_DECODE);
    plain("j_jump", S_JUMP);

    // addi with overflow, then without
    op = 6'b001000;
    fetch_ok("addi_ovf_fetch");
    plain("addi_ovf_decode", S_DECODE);
    e = base(S_IMMEX); e.extop = 1'b1;
    step("addi_ovf_immex", e);
    Overflow = 1'b1;
    e = base(S_IMMWB); e.ovf_trap = 1'b1;
    step("addi_immwb_ovf", e);
    fetch_ok("addi_fetch_trap_gone");
    Overflow = 1'b0;
    plain("addi_decode", S_DECODE);
    e = base(S_IMMEX); e.extop = 1'b1;
    step("addi_immex", e);
    e = base(S_IMMWB); e.regwr = 1'b1;
    step("addi_immwb", e);

    // ori: zero-extend, OR, never traps
    op = 6'b001101;
    fetch_ok("ori_fetch");
    plain("ori_decode", S_DECODE);
    Overflow = 1'b1;
    e = base(S_IMMEX); e.aluctr = 3'b011;
    step("ori_immex", e);
    e = base(S_IMMWB); e.aluctr = 3'b011; e.regwr = 1'b1;
    step("ori_immwb_no_trap", e);
    Overflow = 1'b0;

    // sw with memory stuck: four stalls abort, mem_err follows
    op = 6'b101011;
    fetch_ok("sw_fetch");
    mem_ready = 1'b0;
    plain("sw_decode", S_DECODE);
    plain("sw_memadr", S_MEMADR);
    repeat (4) plain("sw_memwr_stall", S_MEMWR);
    e = base(S_FETCH); e.mem_err = 1'b1;
    step("sw_abort_mem_err", e);
    // FETCH timeout: stalls counted from the aborted-fetch cycle
    repeat (3) plain("fetch_stall", S_FETCH);
    e = base(S_FETCH); e.mem_err = 1'b1;
    step("fetch_abort_mem_err", e);

    // illegal opcode
    op = 6'b111111;
    fetch_ok("illegal_op_fetch");
    mem_ready = 1'b0;
    e = base(S_DECODE); e.illegal = 1'b1;
    step("illegal_op_decode", e);

    // reset in the middle of a stalled lw
    op = 6'b100011;
    fetch_ok("rst_lw_fetch");
    mem_ready = 1'b0;
    plain("rst_lw_decode", S_DECODE);
    plain("rst_lw_memadr", S_MEMADR);
    plain("rst_lw_memrd", S_MEMRD);
    rst_n = 1'b0;
    plain("rst_held", S_INIT);
    rst_n = 1'b1;
    plain("rst_init_one_cycle", S_INIT);
    // counter must restart at zero: three stalls are tolerated
    repeat (3) plain("rst_fetch_stall", S_FETCH);
    fetch_ok("rst_fetch_done");
    mem_ready = 1'b0;
    plain("rst_decode", S_DECODE);

    // drain the scoreboard with a bounded wait
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM controller that sequences a shared-memory multi-cycle MIPS-subset datapath.
- It reuses one ALU and one memory port across 3-5 cycles per instruction.
- It issues the same control signal set as the single-cycle decoder, plus IR/PC write enables, memory request handshake and fault reporting.
- It sits between the instruction register (op/func) and the datapath muxes/enables.

Parameters:
MEM_TIMEOUT, 16, consecutive mem_ready-low cycles tolerated in a memory state before abort (2..255)
CNT_W, 8, width of wait counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from DECODE onward
func  in  6  IR[5:0]
Zero  in  1  ALU zero flag (combinational, current ALU inputs)
Overflow  in  1  registered ALU overflow of previous EXEC/IMMEX cycle
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
MemWr  out  1  memory write (with mem_req)
IorD  out  1  0=PC address, 1=ALUOut address
IRWr  out  1  load instruction register
PCWr  out  1  load PC
PC_Sel  out  2  00=ALU result, 01=ALUOut (branch), 10=jump target
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
Extop  out  1  1=sign extend, 0=zero extend
ALUctr  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
RegWr  out  1  register file write
RegDst  out  1  1=rd, 0=rt
MemtoReg  out  1  1=MDR, 0=ALUOut
illegal  out  1  1-cycle pulse, unsupported op/func
mem_err  out  1  registered 1-cycle pulse, memory timeout
ovf_trap  out  1  1-cycle pulse, writeback suppressed on overflow
state_o  out  4  current state code for debug

Behaviour:
- States: INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, IMMEX=11, IMMWB=12.
- Reset: state=INIT, wait counter=0, mem_err=0. All outputs are 0 in INIT. INIT->FETCH unconditionally next cycle. Reset mid-instruction aborts with no further writes.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=000. IRWr=PCWr=mem_ready. Next state DECODE when mem_ready, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, Extop=1, ALUctr=000. Next state by op:
  - 000000 (R-type) -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) or 001101 (ori) -> IMMEX
  - other -> FETCH with illegal=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, Extop=1, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1. Next state MEMWB on mem_ready.
- MEMWB: RegWr=1, RegDst=0, MemtoReg=1. Next state FETCH.
- MEMWR: mem_req=1, MemWr=1, IorD=1. Next state FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUctr decoded from func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other func: illegal=1, next state FETCH. Otherwise next state ALUWB.
- ALUWB: RegDst=1, ALUctr held. RegWr=~(Overflow & func in {add,sub}). ovf_trap=1 when suppressed. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PC_Sel=01, PCWr=Zero. Next state FETCH.
- JUMP: PCWr=1, PC_Sel=10. Next state FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. addi: Extop=1, add. ori: Extop=0, or. Next state IMMWB.
- IMMWB: RegDst=0, ALUctr held. RegWr=~(Overflow & op==addi). ovf_trap on suppression. Next state FETCH.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on any state change.
  - If mem_ready=0 and count==MEM_TIMEOUT-1: next state FETCH, counter cleared, mem_err=1 on the following cycle.
  - mem_ready=1 on that same cycle wins (normal completion, no mem_err).
  - An aborted access produces no IRWr, PCWr or RegWr.
- CPI: lw 5, sw 4, R-type/addi/ori 4, beq/j 3 (zero-wait memory).

Test Plan:
- rst_n low mid-MEMRD, release -> state_o=0 with all outputs 0 for one cycle, then state_o=1 with mem_req=1.
- R-type add (func 100000), mem_ready=1 always -> states 1,2,7,8,1. ALUctr=000 in EXEC. RegWr=1, RegDst=1 in ALUWB.
- lw with mem_ready held low 3 cycles in MEMRD -> MEMRD lasts 4 cycles, then MEMWB with RegWr=1, MemtoReg=1. Total 8 cycles.
- beq: Zero=1 -> PCWr=1, PC_Sel=01 in BRANCH. Repeat with Zero=0 -> PCWr=0. Both return to FETCH.
- addi with Overflow=1 in IMMWB -> RegWr=0, ovf_trap=1 for exactly one cycle. Same with Overflow=0 -> RegWr=1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in MEMWR -> after 4 cycles returns to FETCH, mem_err high one cycle. op=111111 -> illegal pulse in DECODE, next state FETCH.
